// File: rtl/package_settings.sv
// package_settings: data-path widths shared by the filter chain.
package package_settings;
    localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/v4_parameters.sv
// v4_parameters: timestamp width, counter width and peak-detector state encoding.
package v4_parameters;
    localparam int SIZE_TIME = 16;
    localparam int SIZE_PEAK_CNT = 16;
    typedef enum logic [1:0] {IDLE, ARMED, DEAD} peak_state_t;
endpackage

// File: rtl/v4_peak_detector.sv
// v4_peak_detector: reports the maximum sample of each above-threshold pulse,
// with pile-up flagging and a dead time after every reported peak.
module v4_peak_detector
    import package_settings::*;
    import v4_parameters::*;
#(
    parameter int THRESHOLD = 100,
    parameter int MAX_WIDTH = 64,
    parameter int DEAD_TIME = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
    output logic        [SIZE_TIME-1:0]        peak_time,
    output logic                               peak_valid,
    output logic                               pileup,
    output logic                               busy
);
    // width_cnt is cleared on the trigger sample, so it holds (above samples - 1)
    localparam logic [SIZE_PEAK_CNT-1:0] W_LAST = SIZE_PEAK_CNT'(MAX_WIDTH - 2);
    localparam logic [SIZE_PEAK_CNT-1:0] D_LAST = SIZE_PEAK_CNT'(DEAD_TIME);

    peak_state_t                        state, state_nxt;
    logic signed [SIZE_FILTER_DATA-1:0] max;
    logic        [SIZE_TIME-1:0]        timestamp, max_time;
    logic        [SIZE_PEAK_CNT-1:0]    width_cnt, dead_cnt;
    logic                               above, higher, done, pile;

    assign above  = int'(input_data) > THRESHOLD;
    assign higher = above && (input_data > max);
    assign busy   = state != IDLE;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        pile      = 1'b0;
        unique case (state)
            IDLE:    state_nxt = above ? ARMED : IDLE;
            ARMED: begin
                done      = !above || (width_cnt >= W_LAST);
                pile      = above;
                state_nxt = done ? DEAD : ARMED;
            end
            DEAD:    state_nxt = (dead_cnt >= D_LAST && !above) ? IDLE : DEAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            timestamp      <= '0;
            max            <= '0;
            max_time       <= '0;
            width_cnt      <= '0;
            dead_cnt       <= '0;
            peak_amplitude <= '0;
            peak_time      <= '0;
            peak_valid     <= 1'b0;
            pileup         <= 1'b0;
        end else begin
            state      <= state_nxt;
            timestamp  <= timestamp + SIZE_TIME'(1);
            peak_valid <= done;
            if ((state == IDLE && above) || (state == ARMED && higher)) begin
                max      <= input_data;
                max_time <= timestamp;
            end
            if (state == IDLE)
                width_cnt <= '0;
            else if (state == ARMED && above && width_cnt != '1)
                width_cnt <= width_cnt + SIZE_PEAK_CNT'(1);
            dead_cnt <= (state != DEAD) ? '0 : (dead_cnt < D_LAST) ? dead_cnt + SIZE_PEAK_CNT'(1) : dead_cnt;
            // a pile-up ending sample can itself be the new maximum
            if (done) begin
                peak_amplitude <= higher ? input_data : max;
                peak_time      <= higher ? timestamp : max_time;
                pileup         <= pile;
            end
        end
    end
endmodule

// File: tb/tb_v4_peak_detector.sv
// tb_v4_peak_detector: directed scenarios with hand-computed peaks, stamps and flags.
module tb_v4_peak_detector;
    import package_settings::*;
    import v4_parameters::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic signed [SIZE_FILTER_DATA-1:0] input_data = '0;
    logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude;
    logic [SIZE_TIME-1:0] peak_time;
    logic [SIZE_TIME-1:0] ts = '0;
    logic [SIZE_TIME-1:0] stamp = '0;
    logic [SIZE_TIME-1:0] t_exp = '0;
    logic peak_valid, pileup, busy;
    int nvec = 0;
    int nerr = 0;
    int pv_count = 0;
    int pv_base = 0;

    v4_peak_detector #(.THRESHOLD(100), .MAX_WIDTH(64), .DEAD_TIME(8)) dut (
        .clk(clk),
        .reset(reset),
        .input_data(input_data),
        .peak_amplitude(peak_amplitude),
        .peak_time(peak_time),
        .peak_valid(peak_valid),
        .pileup(pileup),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // one sample per edge; stamp is the timestamp the DUT should attach to it
    task automatic drive(input int v);
        input_data = SIZE_FILTER_DATA'(v);
        @(posedge clk);
        stamp = ts;
        ts = reset ? ts + SIZE_TIME'(1) : '0;
        #1;
        if (peak_valid) pv_count++;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(300);
        drive(300);
        nvec++; if (peak_amplitude !== 16'sd0) begin nerr++; $display("FAIL reset_amp: got %0d want 0", peak_amplitude); end
        nvec++; if (peak_time !== 16'd0) begin nerr++; $display("FAIL reset_time: got %0d want 0", peak_time); end
        nvec++; if (peak_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", peak_valid); end
        nvec++; if (pileup !== 1'b0) begin nerr++; $display("FAIL reset_pileup: got %b want 0", pileup); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
    endtask

    task automatic test_basic;
        pv_base = pv_count;
        drive(0); drive(50); drive(150); drive(300);
        t_exp = stamp;
        drive(250); drive(120);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy: got %b want 1", busy); end
        nvec++; if (peak_valid !== 1'b0) begin nerr++; $display("FAIL basic_early: got %b want 0", peak_valid); end
        drive(80);
        nvec++; if (peak_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid: got %b want 1", peak_valid); end
        nvec++; if (peak_amplitude !== 16'sd300) begin nerr++; $display("FAIL basic_amp: got %0d want 300", peak_amplitude); end
        nvec++; if (peak_time !== t_exp) begin nerr++; $display("FAIL basic_time: got %0d want %0d", peak_time, t_exp); end
        nvec++; if (pileup !== 1'b0) begin nerr++; $display("FAIL basic_pileup: got %b want 0", pileup); end
        drive(0);
        nvec++; if (peak_valid !== 1'b0) begin nerr++; $display("FAIL basic_strobe: got %b want 0", peak_valid); end
        nvec++; if (peak_amplitude !== 16'sd300) begin nerr++; $display("FAIL basic_hold: got %0d want 300", peak_amplitude); end
        repeat (12) drive(0);
        nvec++; if (pv_count !== pv_base + 1) begin nerr++; $display("FAIL basic_count: got %0d want %0d", pv_count, pv_base + 1); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_idle: got %b want 0", busy); end
    endtask

    task automatic test_plateau;
        drive(0); drive(200);
        t_exp = stamp;
        drive(200); drive(150); drive(0);
        nvec++; if (peak_valid !== 1'b1) begin nerr++; $display("FAIL plateau_valid: got %b want 1", peak_valid); end
        nvec++; if (peak_amplitude !== 16'sd200) begin nerr++; $display("FAIL plateau_amp: got %0d want 200", peak_amplitude); end
        nvec++; if (peak_time !== t_exp) begin nerr++; $display("FAIL plateau_time: got %0d want %0d", peak_time, t_exp); end
        repeat (12) drive(0);
    endtask

    task automatic test_pileup;
        pv_base = pv_count;
        drive(500);
        t_exp = stamp;
        repeat (62) drive(500);
        nvec++; if (pv_count !== pv_base) begin nerr++; $display("FAIL pile_early: got %0d events want 0", pv_count - pv_base); end
        drive(500);
        nvec++; if (peak_valid !== 1'b1) begin nerr++; $display("FAIL pile_valid: got %b want 1", peak_valid); end
        nvec++; if (peak_amplitude !== 16'sd500) begin nerr++; $display("FAIL pile_amp: got %0d want 500", peak_amplitude); end
        nvec++; if (peak_time !== t_exp) begin nerr++; $display("FAIL pile_time: got %0d want %0d", peak_time, t_exp); end
        nvec++; if (pileup !== 1'b1) begin nerr++; $display("FAIL pile_flag: got %b want 1", pileup); end
        repeat (16) drive(500);
        nvec++; if (pv_count !== pv_base + 1) begin nerr++; $display("FAIL pile_retrig: got %0d events want 1", pv_count - pv_base); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL pile_busy: got %b want 1", busy); end
        drive(50);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL pile_release: got %b want 0", busy); end
        repeat (4) drive(0);
    endtask

    task automatic test_dead_time;
        pv_base = pv_count;
        drive(0); drive(200); drive(300); drive(200); drive(0);
        nvec++; if (peak_amplitude !== 16'sd300) begin nerr++; $display("FAIL dead_first_amp: got %0d want 300", peak_amplitude); end
        drive(0); drive(0);
        drive(200); drive(400); drive(200);
        repeat (20) drive(0);
        nvec++; if (pv_count !== pv_base + 1) begin nerr++; $display("FAIL dead_ignore: got %0d events want 1", pv_count - pv_base); end
        nvec++; if (peak_amplitude !== 16'sd300) begin nerr++; $display("FAIL dead_ignore_amp: got %0d want 300", peak_amplitude); end
        drive(200); drive(300); drive(0);
        repeat (11) drive(0);
        drive(200); drive(400);
        t_exp = stamp;
        drive(200); drive(0);
        nvec++; if (peak_valid !== 1'b1) begin nerr++; $display("FAIL dead_second_valid: got %b want 1", peak_valid); end
        nvec++; if (peak_amplitude !== 16'sd400) begin nerr++; $display("FAIL dead_second_amp: got %0d want 400", peak_amplitude); end
        nvec++; if (peak_time !== t_exp) begin nerr++; $display("FAIL dead_second_time: got %0d want %0d", peak_time, t_exp); end
        nvec++; if (pileup !== 1'b0) begin nerr++; $display("FAIL dead_second_pileup: got %b want 0", pileup); end
        repeat (12) drive(0);
    endtask

    task automatic test_reset_mid;
        pv_base = pv_count;
        drive(0); drive(200);
        reset = 1'b0;
        drive(300);
        nvec++; if (peak_amplitude !== 16'sd0) begin nerr++; $display("FAIL mid_amp: got %0d want 0", peak_amplitude); end
        nvec++; if (peak_time !== 16'd0) begin nerr++; $display("FAIL mid_time: got %0d want 0", peak_time); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %b want 0", busy); end
        reset = 1'b1;
        drive(0); drive(0);
        nvec++; if (pv_count !== pv_base) begin nerr++; $display("FAIL mid_discard: got %0d events want 0", pv_count - pv_base); end
        drive(150); drive(350); drive(0);
        nvec++; if (peak_amplitude !== 16'sd350) begin nerr++; $display("FAIL mid_next_amp: got %0d want 350", peak_amplitude); end
        nvec++; if (peak_time !== 16'd3) begin nerr++; $display("FAIL mid_next_time: got %0d want 3", peak_time); end
        repeat (12) drive(0);
    endtask

    task automatic test_negative;
        pv_base = pv_count;
        drive(-500); drive(-20);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL neg_busy: got %b want 0", busy); end
        drive(100);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL thr_equal: got %b want 0", busy); end
        drive(101);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL thr_above: got %b want 1", busy); end
        drive(0);
        nvec++; if (peak_amplitude !== 16'sd101) begin nerr++; $display("FAIL thr_amp: got %0d want 101", peak_amplitude); end
        nvec++; if (pv_count !== pv_base + 1) begin nerr++; $display("FAIL neg_count: got %0d events want 1", pv_count - pv_base); end
        repeat (12) drive(0);
    endtask

    task automatic test_wrap;
        while (ts != 16'hFFFD) drive(0);
        drive(200); drive(300); drive(400); drive(450); drive(500); drive(0);
        nvec++; if (peak_valid !== 1'b1) begin nerr++; $display("FAIL wrap_valid: got %b want 1", peak_valid); end
        nvec++; if (peak_amplitude !== 16'sd500) begin nerr++; $display("FAIL wrap_amp: got %0d want 500", peak_amplitude); end
        nvec++; if (peak_time !== 16'd1) begin nerr++; $display("FAIL wrap_time: got %0d want 1", peak_time); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_plateau;
        test_pileup;
        test_dead_time;
        test_reset_mid;
        test_negative;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/v4_peak_detector.md
V4_PEAK_DETECTOR -- requirements
Module: v4_peak_detector

Interface
REQ-001 Parameter THRESHOLD, default 100: signed trigger level; a sample is "above" when input_data > THRESHOLD (strict).
REQ-002 Parameter MAX_WIDTH, default 64: maximum number of above-threshold cycles before a pulse is declared pile-up.
REQ-003 Parameter DEAD_TIME, default 8: number of cycles ignored after each reported peak.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 input_data  input  SIZE_FILTER_DATA  trapezoidal-filter output, one sample per clk, two's-complement signed.
REQ-007 peak_amplitude  output  SIZE_FILTER_DATA  maximum sample of the reported pulse, signed.
REQ-008 peak_time  output  SIZE_TIME  timestamp of that maximum sample.
REQ-009 peak_valid  output  1  one-cycle strobe qualifying peak_amplitude, peak_time and pileup.
REQ-010 pileup  output  1  set with peak_valid when the pulse hit MAX_WIDTH.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 A free-running SIZE_TIME-bit timestamp counter SHALL increment every cycle, wrap from all-ones to 0, and stamp the sample captured on the same edge.
REQ-013 The FSM SHALL have states IDLE, ARMED, DEAD.
REQ-014 In IDLE, a captured sample above THRESHOLD SHALL load max with that sample, max_time with its stamp, clear the width counter and move to ARMED.
REQ-015 In ARMED, a sample strictly greater than max SHALL replace max and max_time; equal samples SHALL NOT, so the earliest sample of a plateau is reported.
REQ-016 In ARMED, a sample <= THRESHOLD SHALL end the pulse: peak_valid=1, pileup=0 on the next cycle, move to DEAD.
REQ-017 In ARMED, when the width counter reaches MAX_WIDTH above-threshold samples, the pulse SHALL end with pileup=1, regardless of the current sample.
REQ-018 Latency: peak_valid SHALL be high for exactly the one cycle following the edge that captured the ending sample; peak_amplitude/peak_time/pileup SHALL hold their values until the next peak_valid.
REQ-019 In DEAD, a counter SHALL run DEAD_TIME cycles with input ignored; afterwards return to IDLE only on a sample <= THRESHOLD, otherwise remain in DEAD (no retrigger on a still-high signal).
REQ-020 All comparisons SHALL be signed; negative samples are never above a non-negative THRESHOLD.
REQ-021 The width and dead counters SHALL saturate, never wrap.

Reset
REQ-022 While reset=0 on an edge: state=IDLE; timestamp, max, max_time, counters, peak_amplitude, peak_time = 0; peak_valid, pileup, busy = 0.
REQ-023 Reset asserted mid-pulse SHALL discard the pulse with no peak_valid; the first sample after release is treated as in IDLE.

Structure
REQ-024 SIZE_FILTER_DATA SHALL come from package_settings; SIZE_TIME and the FSM state enum SHALL be added to v4_parameters.
REQ-025 The block SHALL be a single module, instantiated directly after v4_filter with input_data driven by its output_data; no sub-module.

Verification (THRESHOLD=100, MAX_WIDTH=64, DEAD_TIME=8)
REQ-026 Samples 0,50,150,300,250,120,80 -> one peak_valid one cycle after 80 captured, amplitude 300, peak_time = stamp of 300, pileup 0.
REQ-027 Samples 0,200,200,150,0 -> amplitude 200, peak_time = stamp of first 200.
REQ-028 Constant 500 for 80 cycles -> peak_valid after 64th above sample, amplitude 500, pileup 1; no second event until input falls to <= 100.
REQ-029 Pulse peak 300, then second pulse peak 400 starting 3 cycles after peak_valid -> ignored; same pulse starting 12 cycles after (input low in between) -> reported amplitude 400.
REQ-030 Reset low for one cycle during ARMED at sample 300 -> no peak_valid, all outputs 0; next pulse reported normally.
REQ-031 Samples -500,-20,100 -> no trigger; timestamp preloaded near all-ones -> peak_time wraps correctly to small value.
